burst_mem_responder: RTL and testbench
======================================

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32, the width of one data beat.
REQ-002 SHALL take parameter DATA_ADDR_WIDTH, default 32, the width of the byte address.
REQ-003 SHALL take parameter NUM_WORDS, default 128, the memory depth in words (power of two).
REQ-004 SHALL take parameter READ_BURST_LEN, default 8, the beats per read burst.
REQ-005 SHALL take parameter WRITE_BURST_LEN, default 8, the beats per write burst.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port sys_rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port req_valid, input, 1 bit: burst request present.
REQ-010 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-011 SHALL have port req_write, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-012 SHALL have port req_addr, input, DATA_ADDR_WIDTH bits: burst start byte address.
REQ-013 SHALL have ports wdata_valid (input, 1), wdata_ready (output, 1), wdata (input, DATA_WIDTH) and wdata_last (input, 1) forming the write-beat channel.
REQ-014 SHALL have ports rdata_valid (output, 1), rdata_ready (input, 1), rdata (output, DATA_WIDTH) and rdata_last (output, 1) forming the read-beat channel.
REQ-015 SHALL have ports wresp_valid (output, 1) and wresp_ready (input, 1) forming the write-completion channel.
REQ-016 SHALL have port err_last, output, 1 bit: sticky flag for a wdata_last mismatch.

Function
REQ-017 SHALL address the memory by word, with index = req_addr[2 +: log2(NUM_WORDS)]; the lower two address bits and the bits above the index are ignored.
REQ-018 SHALL use index + k modulo NUM_WORDS for beat k, so a burst wraps from the last word to word 0.
REQ-019 SHALL implement a state machine with states IDLE, RD, WR and WRESP.
REQ-020 SHALL assert req_ready only in IDLE; a handshake moves the state to RD or WR according to req_write and latches the index.
REQ-021 In RD, SHALL assert rdata_valid from the cycle after acceptance.
REQ-022 In RD, SHALL hold rdata and rdata_last stable while rdata_valid is high and rdata_ready is low.
REQ-023 In RD, SHALL sustain one beat per cycle while rdata_ready is held high.
REQ-024 SHALL present the next word's index to the RAM in the same cycle as a read handshake, and the current index otherwise.
REQ-025 SHALL assert rdata_last on beat READ_BURST_LEN-1 only; the handshake on that beat returns the state to IDLE and deasserts rdata_valid in the next cycle.
REQ-026 In WR, SHALL assert wdata_ready.
REQ-027 In WR, SHALL write each accepted beat to its word in the same cycle as the handshake.
REQ-028 After WRITE_BURST_LEN accepted beats, SHALL move to WRESP.
REQ-029 SHALL set err_last when wdata_last disagrees with (beat == WRITE_BURST_LEN-1); the beat is still written.
REQ-030 In WRESP, SHALL assert wresp_valid until wresp_ready is seen, then return to IDLE.
REQ-031 SHALL keep wdata_ready low outside WR; write beats presented early are not consumed.
REQ-032 SHALL count beats with a counter of width log2(max burst)+1 that clears on every request acceptance.
REQ-033 SHALL support back-to-back requests: the request following a last read beat is accepted no earlier than the next cycle, which is IDLE.

Reset
REQ-034 On sys_rst, SHALL set state to IDLE and clear the beat counter.
REQ-035 On sys_rst, SHALL drive req_ready to 1 after the reset cycle.
REQ-036 On sys_rst, SHALL clear rdata_valid, rdata_last, wdata_ready, wresp_valid and err_last to 0, and clear rdata to 0.
REQ-037 On sys_rst, SHALL abort any burst in progress with no further memory writes and no response; memory contents are not reset.

Structure
REQ-038 SHALL place the state enum (IDLE/RD/WR/WRESP) and the beat-counter width function in the shared package burst_mem_pkg.
REQ-039 SHALL instantiate one sub-module, mem_sp_ram: a synchronous single-port RAM with a registered read and a write on we, NUM_WORDS x DATA_WIDTH.

Verification
REQ-040 Bench SHALL cover: write burst at addr 0x40 with data 0x1000_0000+i (i=0..7), then a read burst at 0x40 -> rdata 0x1000_0000..0x1000_0007 on consecutive cycles, last on beat 7, one wresp.
REQ-041 Bench SHALL cover: read at 0x40 with rdata_ready toggled 1,0,0,1,... -> no beat lost or duplicated, rdata stable during stalls, 8 handshakes.
REQ-042 Bench SHALL cover: write burst at 0x1F0 with data 0xA0+i -> words 124..127 then 0..3 hold 0xA0..0xA7; read back at 0x1F0 matches.
REQ-043 Bench SHALL cover: sys_rst asserted after 3 write beats at 0x00 (data 0x55) -> words 3..7 are unchanged, wresp_valid never rises, req_ready is 1 after reset.
REQ-044 Bench SHALL cover: req_valid held high during a read burst -> req_ready is 0 until the cycle after the last read handshake; wdata_valid in IDLE -> wdata_ready stays 0.
REQ-045 Bench SHALL cover: wdata_last asserted on beat 5 -> err_last is 1 from the next cycle and stays set until reset.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// rtl/burst_mem_pkg.sv - shared FSM state type and beat-counter sizing for the burst responder
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        WRESP = 2'd3
    } state_e;

    // One extra bit so the counter can represent a full burst without aliasing to zero.
    function automatic int beat_cnt_width(input int rd_len, input int wr_len);
        int max_len;
        max_len = (rd_len > wr_len) ? rd_len : wr_len;
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// rtl/mem_sp_ram.sv - single-port synchronous RAM with registered read and write-enable
module mem_sp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 128,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - fixed-length read/write burst responder over a wrapping word memory
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [DATA_ADDR_WIDTH-1:0] req_addr,
    input  logic                       wdata_valid,
    output logic                       wdata_ready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       wdata_last,
    output logic                       rdata_valid,
    input  logic                       rdata_ready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rdata_last,
    output logic                       wresp_valid,
    input  logic                       wresp_ready,
    output logic                       err_last
);

    localparam int AW = $clog2(NUM_WORDS);
    localparam int CW = beat_cnt_width(READ_BURST_LEN, WRITE_BURST_LEN);
    localparam logic [CW-1:0] RD_LAST = CW'(READ_BURST_LEN - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_BURST_LEN - 1);

    state_e          state_q;
    logic [CW-1:0]   beat_q;
    logic [AW-1:0]   ptr_q;
    logic            req_ready_q;
    logic            rdata_valid_q;
    logic            rdata_last_q;
    logic            wdata_ready_q;
    logic            wresp_valid_q;
    logic            err_last_q;

    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   ram_addr_d;
    logic            ram_we;
    logic            req_hs;
    logic            rd_hs;
    logic            wr_hs;
    logic            unused_addr;

    assign req_idx     = req_addr[2 +: AW];
    assign unused_addr = ^req_addr;

    assign req_hs = req_valid && req_ready_q;
    assign rd_hs  = rdata_valid_q && rdata_ready;
    assign wr_hs  = wdata_valid && wdata_ready_q;
    assign ram_we = wr_hs && !sys_rst;

    // In IDLE the incoming index is fed straight to the RAM so the first beat is ready next cycle.
    always_comb begin
        ram_addr_d = ptr_q;
        if (state_q == IDLE) begin
            ram_addr_d = req_idx;
        end else if (rd_hs) begin
            ram_addr_d = ptr_q + AW'(1);
        end
    end

    mem_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .we_i    (ram_we),
        .addr_i  (ram_addr_d),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            ptr_q         <= '0;
            req_ready_q   <= 1'b1;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wdata_ready_q <= 1'b0;
            wresp_valid_q <= 1'b0;
            err_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hs) begin
                        beat_q      <= '0;
                        ptr_q       <= req_idx;
                        req_ready_q <= 1'b0;
                        if (req_write) begin
                            state_q       <= WR;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q       <= RD;
                            rdata_valid_q <= 1'b1;
                            rdata_last_q  <= (RD_LAST == '0);
                        end
                    end
                end
                RD: begin
                    if (rd_hs) begin
                        ptr_q        <= ptr_q + AW'(1);
                        beat_q       <= beat_q + CW'(1);
                        rdata_last_q <= (beat_q + CW'(1) == RD_LAST);
                        if (rdata_last_q) begin
                            state_q       <= IDLE;
                            rdata_valid_q <= 1'b0;
                            rdata_last_q  <= 1'b0;
                            req_ready_q   <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        if (wdata_last != (beat_q == WR_LAST)) begin
                            err_last_q <= 1'b1;
                        end
                        ptr_q  <= ptr_q + AW'(1);
                        beat_q <= beat_q + CW'(1);
                        if (beat_q == WR_LAST) begin
                            state_q       <= WRESP;
                            wdata_ready_q <= 1'b0;
                            wresp_valid_q <= 1'b1;
                        end
                    end
                end
                WRESP: begin
                    if (wresp_ready) begin
                        state_q       <= IDLE;
                        wresp_valid_q <= 1'b0;
                        req_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign wdata_ready = wdata_ready_q;
    assign wresp_valid = wresp_valid_q;
    assign err_last    = err_last_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed self-checking bench for burst_mem_responder
module tb_burst_mem_responder;

    logic        sys_clk;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        wdata_last;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [31:0] rdata;
    logic        rdata_last;
    logic        wresp_valid;
    logic        wresp_ready;
    logic        err_last;

    logic [31:0] model [128];
    int          checks;
    int          failures;

    burst_mem_responder dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .wdata_last  (wdata_last),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .wresp_valid (wresp_valid),
        .wresp_ready (wresp_ready),
        .err_last    (err_last)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [31:0] base, input int last_beat);
        int n;
        logic [6:0] widx;
        req_write = 1'b1;
        req_addr  = addr;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk("wr_req_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wdata_valid = 1'b1;
            wdata       = base + i;
            wdata_last  = (i == last_beat);
            n = 0;
            while (!wdata_ready && n < 20) begin step(); n++; end
            chk("wr_beat_ready", 32'(wdata_ready), 1);
            if (last_beat != 7 && i == last_beat) chk("err_before", 32'(err_last), 0);
            step();
            widx = 7'(addr[8:2] + 7'(i));
            model[widx] = base + i;
            if (last_beat != 7 && i == last_beat) chk("err_after", 32'(err_last), 1);
        end
        wdata_valid = 1'b0;
        wdata_last  = 1'b0;
        chk("wresp_rise", 32'(wresp_valid), 1);
        wresp_ready = 1'b1;
        step();
        wresp_ready = 1'b0;
        chk("wresp_drop", 32'(wresp_valid), 0);
        chk("idle_after_wr", 32'(req_ready), 1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input bit toggle);
        int beat;
        int cyc;
        int n;
        bit stalled;
        logic [31:0] held_d;
        logic        held_l;
        logic [6:0]  ridx;
        req_write = 1'b0;
        req_addr  = addr;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk("rd_req_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        chk("rd_first_valid", 32'(rdata_valid), 1);
        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (beat < 8 && cyc < 60) begin
            rdata_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (rdata_valid) begin
                if (rdata_ready) begin
                    ridx = 7'(addr[8:2] + 7'(beat));
                    chk("rd_data", rdata, model[ridx]);
                    chk("rd_last", 32'(rdata_last), 32'(beat == 7));
                    beat++;
                end else begin
                    held_d  = rdata;
                    held_l  = rdata_last;
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
            if (stalled) begin
                chk("rd_stall_data", rdata, held_d);
                chk("rd_stall_last", 32'(rdata_last), 32'(held_l));
                stalled = 1'b0;
            end
            if (!toggle && beat < 8) chk("rd_consecutive", 32'(rdata_valid), 1);
        end
        rdata_ready = 1'b0;
        chk("rd_beats", beat, 8);
        chk("rd_valid_done", 32'(rdata_valid), 0);
        chk("rd_idle_ready", 32'(req_ready), 1);
    endtask

    initial begin
        int   n;
        int   beat;
        logic saw;

        checks = 0;
        failures = 0;
        sys_rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        wdata_valid = 1'b0;
        wdata = '0;
        wdata_last = 1'b0;
        rdata_ready = 1'b0;
        wresp_ready = 1'b0;
        step();
        step();
        sys_rst = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rdata_valid", 32'(rdata_valid), 0);
        chk("rst_rdata_last", 32'(rdata_last), 0);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        chk("rst_wresp_valid", 32'(wresp_valid), 0);
        chk("rst_err_last", 32'(err_last), 0);
        chk("rst_rdata", rdata, 0);

        write_burst(32'h40, 32'h1000_0000, 7);
        chk("err_clean", 32'(err_last), 0);
        read_burst(32'h40, 1'b0);
        read_burst(32'h40, 1'b1);

        write_burst(32'h1F0, 32'hA0, 7);
        chk("wrap_w127", model[127], 32'hA3);
        chk("wrap_w0", model[0], 32'hA4);
        read_burst(32'h1F0, 1'b0);

        // Aborted write: three 0x55 beats land, the fourth coincides with reset.
        write_burst(32'h00, 32'hB0, 7);
        req_write = 1'b1;
        req_addr = 32'h00;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wdata_valid = 1'b1;
            wdata = 32'h55;
            chk("abort_beat_ready", 32'(wdata_ready), 1);
            step();
            model[i] = 32'h55;
        end
        wdata_valid = 1'b1;
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        wdata_valid = 1'b0;
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_wdata_ready", 32'(wdata_ready), 0);
        saw = wresp_valid;
        for (int i = 0; i < 4; i++) begin step(); saw = saw | wresp_valid; end
        chk("abort_no_wresp", 32'(saw), 0);
        read_burst(32'h00, 1'b0);

        wdata_valid = 1'b1;
        wdata = 32'hDEAD;
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin saw = saw | wdata_ready; step(); end
        wdata_valid = 1'b0;
        chk("idle_wdata_ready", 32'(saw), 0);

        // Request held high across a read burst: next accept only after the last beat.
        req_write = 1'b0;
        req_addr = 32'h40;
        req_valid = 1'b1;
        rdata_ready = 1'b1;
        step();
        chk("b2b_busy", 32'(req_ready), 0);
        saw = 1'b0;
        beat = 0;
        n = 0;
        while (beat < 8 && n < 30) begin
            saw = saw | req_ready;
            if (rdata_valid) beat++;
            step();
            n++;
        end
        chk("b2b_beats", beat, 8);
        chk("b2b_no_early_ready", 32'(saw), 0);
        chk("b2b_ready_after_last", 32'(req_ready), 1);
        chk("b2b_valid_gap", 32'(rdata_valid), 0);
        step();
        req_valid = 1'b0;
        chk("b2b_second_accept", 32'(rdata_valid), 1);
        n = 0;
        while (!req_ready && n < 30) begin step(); n++; end
        chk("b2b_drained", 32'(req_ready), 1);
        rdata_ready = 1'b0;

        write_burst(32'h80, 32'hC0, 5);
        chk("err_sticky_wr", 32'(err_last), 1);
        read_burst(32'h80, 1'b0);
        chk("err_sticky_rd", 32'(err_last), 1);
        pulse_reset();
        chk("err_cleared", 32'(err_last), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
